// File: rtl/l3_neuron_bwd.sv
// Backward-pass unit for an N-input ReLU neuron: one element per cycle through a shared multiplier pair.
// Optional macro L3_NEURON_BWD_SAT_FLAG_EN adds a sat_flag output reporting any clamp in the transaction.
module l3_neuron_bwd #(
    parameter int N        = 4,
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int LR_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the context is sampled only on that edge, results are held until out_ready is seen.
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   x,
    input  logic [N*WIDTH-1:0]   w,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     y,
    input  logic [WIDTH-1:0]     grad_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WIDTH-1:0]   w_new,
    output logic [WIDTH-1:0]     b_new,
    output logic [N*WIDTH-1:0]   grad_x,
`ifdef L3_NEURON_BWD_SAT_FLAG_EN
    output logic                 sat_flag,
`endif
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic signed [WIDTH-1:0] x_r [N];
    logic signed [WIDTH-1:0] w_r [N];
    logic signed [WIDTH-1:0] wn_r [N];
    logic signed [WIDTH-1:0] gx_r [N];
    logic signed [WIDTH-1:0] b_r, delta_r, bn_r;

    logic signed [WIDTH-1:0] cur_x, cur_w, d_sh;
    logic signed [PW-1:0]    d_ext, x_ext, w_ext;
    logic signed [PW-1:0]    prod_w, prod_x, prod_w_sh, prod_x_sh;
    logic [EW-1:0]           gx_wide, wn_wide, bn_wide;
    logic                    last;

    // Clamp an extended difference/product back into the signed WIDTH range.
    function automatic logic [WIDTH-1:0] sat_val(input logic [EW-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[EW-1:WIDTH-1] == '0 || v[EW-1:WIDTH-1] == '1)
            r = v[WIDTH-1:0];
        else if (v[EW-1])
            r = {1'b1, {(WIDTH-1){1'b0}}};
        else
            r = {1'b0, {(WIDTH-1){1'b1}}};
        return r;
    endfunction

`ifdef L3_NEURON_BWD_SAT_FLAG_EN
    function automatic logic is_ovf(input logic [EW-1:0] v);
        return !(v[EW-1:WIDTH-1] == '0 || v[EW-1:WIDTH-1] == '1);
    endfunction
    logic sat_r;
`endif

    assign cur_x = x_r[idx];
    assign cur_w = w_r[idx];
    assign d_ext = {{WIDTH{delta_r[WIDTH-1]}}, delta_r};
    assign x_ext = {{WIDTH{cur_x[WIDTH-1]}}, cur_x};
    assign w_ext = {{WIDTH{cur_w[WIDTH-1]}}, cur_w};
    assign prod_w    = d_ext * w_ext;
    assign prod_x    = d_ext * x_ext;
    assign prod_w_sh = prod_w >>> FRAC;
    assign prod_x_sh = prod_x >>> (FRAC + LR_SHIFT);
    assign d_sh      = delta_r >>> LR_SHIFT;

    assign gx_wide = {prod_w_sh[PW-1], prod_w_sh};
    assign wn_wide = {{(WIDTH+1){cur_w[WIDTH-1]}}, cur_w} - {prod_x_sh[PW-1], prod_x_sh};
    assign bn_wide = {{(WIDTH+1){b_r[WIDTH-1]}}, b_r} - {{(WIDTH+1){d_sh[WIDTH-1]}}, d_sh};
    assign last    = (idx == IW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            b_r       <= '0;
            delta_r   <= '0;
            bn_r      <= '0;
            for (int i = 0; i < N; i++) begin
                x_r[i]  <= '0;
                w_r[i]  <= '0;
                wn_r[i] <= '0;
                gx_r[i] <= '0;
            end
`ifdef L3_NEURON_BWD_SAT_FLAG_EN
            sat_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            x_r[i] <= x[i*WIDTH +: WIDTH];
                            w_r[i] <= w[i*WIDTH +: WIDTH];
                        end
                        b_r <= b;
                        // ReLU derivative: gradient passes only where the forward output was positive.
                        delta_r <= (!y[WIDTH-1] && (y != '0)) ? grad_y : '0;
                        idx     <= '0;
                        state   <= RUN;
`ifdef L3_NEURON_BWD_SAT_FLAG_EN
                        sat_r <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    gx_r[idx] <= sat_val(gx_wide);
                    wn_r[idx] <= sat_val(wn_wide);
                    idx       <= idx + 1'b1;
`ifdef L3_NEURON_BWD_SAT_FLAG_EN
                    sat_r <= sat_r | is_ovf(gx_wide) | is_ovf(wn_wide) | (last & is_ovf(bn_wide));
`endif
                    if (last) begin
                        bn_r      <= sat_val(bn_wide);
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;
    assign b_new     = bn_r;
`ifdef L3_NEURON_BWD_SAT_FLAG_EN
    assign sat_flag  = sat_r;
`endif

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign w_new[g*WIDTH +: WIDTH]  = wn_r[g];
        assign grad_x[g*WIDTH +: WIDTH] = gx_r[g];
    end

endmodule

// File: tb/tb_l3_neuron_bwd.sv
// Bench for l3_neuron_bwd: vector table, hand-written corner sequences and randomized transactions
// checked against an integer reference model.
module tb_l3_neuron_bwd;

    localparam int N        = 4;
    localparam int WIDTH    = 16;
    localparam int FRAC     = 8;
    localparam int LR_SHIFT = 4;
    localparam int RW       = 2 * N * WIDTH + WIDTH + 1;

    typedef struct packed {
        logic [N-1:0][WIDTH-1:0] x;
        logic [N-1:0][WIDTH-1:0] w;
        logic [WIDTH-1:0]        b;
        logic [WIDTH-1:0]        y;
        logic [WIDTH-1:0]        gy;
        logic [N-1:0][WIDTH-1:0] gx;
        logic [N-1:0][WIDTH-1:0] wn;
        logic [WIDTH-1:0]        bn;
        logic                    sf;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid, in_ready, out_valid, out_ready;
    logic [N*WIDTH-1:0]   x, w, w_new, grad_x;
    logic [WIDTH-1:0]     b, y, grad_y, b_new;
    logic [1:0]           dbg_state;
`ifdef L3_NEURON_BWD_SAT_FLAG_EN
    logic                 sat_flag;
`endif

    logic [RW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    vec_t          tbl[6];

    l3_neuron_bwd #(.N(N), .WIDTH(WIDTH), .FRAC(FRAC), .LR_SHIFT(LR_SHIFT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .w(w), .b(b), .y(y), .grad_y(grad_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .w_new(w_new), .b_new(b_new), .grad_x(grad_x),
`ifdef L3_NEURON_BWD_SAT_FLAG_EN
        .sat_flag(sat_flag),
`endif
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // reference model: plain signed integer arithmetic
    function automatic logic [WIDTH-1:0] sat_w(input longint v, output bit c);
        longint hi, lo;
        hi = (longint'(1) <<< (WIDTH - 1)) - 1;
        lo = -hi - 1;
        c = 1'b1;
        if (v > hi) return WIDTH'(hi);
        if (v < lo) return WIDTH'(lo);
        c = 1'b0;
        return WIDTH'(v);
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t   r;
        longint d, xi, wi;
        bit     c;
        r = v;
        r.sf = 1'b0;
        d = ($signed(v.y) > 0) ? longint'($signed(v.gy)) : longint'(0);
        for (int i = 0; i < N; i++) begin
            xi = longint'($signed(v.x[i]));
            wi = longint'($signed(v.w[i]));
            r.gx[i] = sat_w((d * wi) >>> FRAC, c);
            r.sf = r.sf | c;
            r.wn[i] = sat_w(wi - ((d * xi) >>> (FRAC + LR_SHIFT)), c);
            r.sf = r.sf | c;
        end
        r.bn = sat_w(longint'($signed(v.b)) - (d >>> LR_SHIFT), c);
        r.sf = r.sf | c;
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        bit   big;
        v = '0;
        big = ($urandom_range(0, 1) == 1);
        for (int i = 0; i < N; i++) begin
            v.x[i] = big ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 2047) - 1024);
            v.w[i] = big ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 2047) - 1024);
        end
        v.b  = big ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 4095) - 2048);
        v.gy = big ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 2047) - 1024);
        v.y  = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom);
        return model(v);
    endfunction

    function automatic logic [RW-1:0] exp_res(input vec_t v);
`ifdef L3_NEURON_BWD_SAT_FLAG_EN
        return {v.wn, v.bn, v.gx, v.sf};
`else
        return {v.wn, v.bn, v.gx, 1'b0};
`endif
    endfunction

    function automatic logic [RW-1:0] dut_res();
`ifdef L3_NEURON_BWD_SAT_FLAG_EN
        return {w_new, b_new, grad_x, sat_flag};
`else
        return {w_new, b_new, grad_x, 1'b0};
`endif
    endfunction

    // scoreboard compare
    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // drivers
    task automatic set_inputs(input vec_t v);
        x      = v.x;
        w      = v.w;
        b      = v.b;
        y      = v.y;
        grad_y = v.gy;
    endtask

    task automatic drive_ctx(input vec_t v);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_before_accept", RW'(in_ready), RW'(1));
        set_inputs(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        set_inputs(rand_vec());
        exp_q.push_back(exp_res(v));
    endtask

    task automatic collect(input string name, input int hold);
        int            lat;
        logic [RW-1:0] e;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check({name, "_latency"}, RW'(lat - 1), RW'(N));
        check({name, "_queue"}, RW'(exp_q.size() > 0), RW'(1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({name, "_data"}, dut_res(), e);
        if (hold > 0) begin
            set_inputs(rand_vec());
            in_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({name, "_hold_data"}, dut_res(), e);
                check({name, "_hold_flags"}, RW'({out_valid, in_ready}), RW'(2'b10));
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check({name, "_release"}, RW'({out_valid, in_ready}), RW'(2'b01));
        if (hold > 0) begin
            @(negedge clk);
            check({name, "_no_accept"}, RW'({out_valid, in_ready}), RW'(2'b01));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_inputs('0);

        // table: basic, relu gate, saturation, floor on negatives, bias clamp, mixed
        for (int i = 0; i < 6; i++) tbl[i] = '0;
        tbl[0].x[0] = 16'h0100; tbl[0].w[0] = 16'h0200; tbl[0].y = 16'h0080; tbl[0].gy = 16'h0100;
        tbl[0].gx[0] = 16'h0200; tbl[0].wn[0] = 16'h01F0; tbl[0].bn = 16'hFFF0; tbl[0].sf = 1'b0;

        tbl[1].x[0] = 16'h0100; tbl[1].w[0] = 16'h0200; tbl[1].y = 16'h0000; tbl[1].gy = 16'h0100;
        tbl[1].wn[0] = 16'h0200; tbl[1].bn = 16'h0000; tbl[1].sf = 1'b0;

        tbl[2].x[0] = 16'h7FFF; tbl[2].w[0] = 16'h8000; tbl[2].y = 16'h0001; tbl[2].gy = 16'h7FFF;
        tbl[2].gx[0] = 16'h8000; tbl[2].wn[0] = 16'h8000; tbl[2].bn = 16'hF801; tbl[2].sf = 1'b1;

        tbl[3].x[0] = 16'h0001; tbl[3].w[0] = 16'h0001; tbl[3].x[1] = 16'h0300; tbl[3].w[1] = 16'hFF00;
        tbl[3].b = 16'h0005; tbl[3].y = 16'h0010; tbl[3].gy = 16'hFFFF;
        tbl[3].gx[0] = 16'hFFFF; tbl[3].wn[0] = 16'h0002; tbl[3].gx[1] = 16'h0001; tbl[3].wn[1] = 16'hFF01;
        tbl[3].bn = 16'h0006; tbl[3].sf = 1'b0;

        tbl[4].b = 16'h7FFF; tbl[4].y = 16'h7FFF; tbl[4].gy = 16'h8000;
        tbl[4].bn = 16'h7FFF; tbl[4].sf = 1'b1;

        tbl[5].x  = {16'h0040, 16'hFF80, 16'h0100, 16'h0200};
        tbl[5].w  = {16'h0100, 16'h0080, 16'hFE00, 16'h0010};
        tbl[5].b  = 16'h0100; tbl[5].y = 16'h0100; tbl[5].gy = 16'h0200;
        tbl[5].gx = {16'h0200, 16'h0100, 16'hFC00, 16'h0020};
        tbl[5].wn = {16'h00F8, 16'h0090, 16'hFDE0, 16'hFFD0};
        tbl[5].bn = 16'h00E0; tbl[5].sf = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", RW'({out_valid, in_ready}), RW'(2'b01));
        check("reset_outputs", dut_res(), '0);
        check("reset_state", RW'(dbg_state), RW'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive_ctx(tbl[i]);
            collect($sformatf("vec%0d", i), 0);
        end

        // backpressure: results held for 5 cycles while a new context waits
        drive_ctx(tbl[5]);
        collect("backpressure", 5);

        // reset during the second RUN cycle discards the transaction
        drive_ctx(tbl[0]);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_flags", RW'({out_valid, in_ready}), RW'(2'b01));
        check("midrun_reset_outputs", dut_res(), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_flags", RW'({out_valid, in_ready}), RW'(2'b01));
        drive_ctx(tbl[0]);
        collect("after_reset", 0);

        // back-to-back with in_valid and out_ready held high
        @(negedge clk);
        set_inputs(tbl[5]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) set_inputs(tbl[3]);
            if (e == 6) in_valid = 1'b0;
            @(negedge clk);
            if (e == 4)  check("b2b_first_data", dut_res(), exp_res(tbl[5]));
            if (e == 4)  check("b2b_first_valid", RW'({out_valid, in_ready}), RW'(2'b10));
            if (e == 5)  check("b2b_idle", RW'({out_valid, in_ready}), RW'(2'b01));
            if (e == 6)  check("b2b_second_accept", RW'(in_ready), RW'(0));
            if (e == 10) check("b2b_second_data", dut_res(), exp_res(tbl[3]));
            if (e == 10) check("b2b_second_valid", RW'(out_valid), RW'(1));
            if (e == 11) check("b2b_done", RW'({out_valid, in_ready}), RW'(2'b01));
        end
        out_ready = 1'b0;

        // randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            drive_ctx(rand_vec());
            collect($sformatf("rand%0d", n), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
